transformation_engine_mlane: RTL and testbench

- Parameterised successor of the GCN feature×weight transformation stage. Computes FM (FEATURE_ROWS×FEATURE_COLS) × WM (WEIGHT_ROWS×WEIGHT_COLS) and stores the product in an internal result buffer.
- Weight columns and feature rows are read from the shared FM/WM memory over a single address/enable port that has configurable read latency.
- LANES weight columns are buffered per pass, so each feature-row fetch yields LANES dot products in parallel.
- Results are saturated or truncated to DOT_PROD_WIDTH and read out row-wise by the downstream combination stage.

---
 rtl/transformation_engine_mlane.sv | 219 +++++++++++++++++++++
 tb/tb_transformation_engine_mlane.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/transformation_engine_mlane.sv
// Multi-lane feature x weight transformation engine.
// Buffers LANES weight columns per pass, then streams every feature row through
// LANES parallel dot-product units. It writes the saturated or truncated results
// into an internal buffer. The combination stage reads that buffer row by row.
module transformation_engine_mlane #(
  parameter int FEATURE_COLS   = 96,
  parameter int WEIGHT_ROWS    = 96,
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DATA_WIDTH     = 5,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int ADDRESS_WIDTH  = 13,
  parameter logic [ADDRESS_WIDTH-1:0] WEIGHT_BASE  = 13'h0000,
  parameter logic [ADDRESS_WIDTH-1:0] FEATURE_BASE = 13'h0200,
  parameter int LANES          = 2,
  parameter int MEM_LATENCY    = 1,
  parameter int SATURATE       = 1,
  parameter int ROW_W          = $clog2(FEATURE_ROWS)
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [WEIGHT_ROWS*DATA_WIDTH-1:0]     data_in,
  output logic [ADDRESS_WIDTH-1:0]              read_address,
  output logic                                  enable_read,
  input  logic [ROW_W-1:0]                      read_row,
  output logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0] fm_wm_row,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  overflow
);

  localparam int GROUPS = (WEIGHT_COLS + LANES - 1) / LANES;
  localparam int SUM_W  = 2 * DATA_WIDTH + $clog2(FEATURE_COLS);
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int RCNT_W = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam int COL_W  = $clog2(WEIGHT_COLS + LANES + 1);
  localparam int WORD_W = WEIGHT_ROWS * DATA_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic                      phase_q, phase_d;      // 0: loading weights, 1: streaming features
  logic [LANE_W-1:0]         lane_q, lane_d;
  logic [RCNT_W-1:0]         row_q, row_d;
  logic [GRP_W-1:0]          group_q, group_d;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic                      overflow_q, overflow_d;
  logic [WORD_W-1:0]         scratch_q [LANES];
  logic [WORD_W-1:0]         scratch_d [LANES];
  logic [DOT_PROD_WIDTH-1:0] result_q [FEATURE_ROWS][WEIGHT_COLS];
  logic [DOT_PROD_WIDTH-1:0] result_d [FEATURE_ROWS][WEIGHT_COLS];

  logic [COL_W-1:0]          col_base;
  logic                      capture;
  logic                      weight_last;
  logic                      row_last;
  logic                      group_last;
  logic [DOT_PROD_WIDTH-1:0] lane_val [LANES];
  logic                      lane_ovf [LANES];

  // Group bookkeeping: the first column of the current group and the end-of-phase flags
  always_comb begin
    col_base    = COL_W'(group_q) * COL_W'(LANES);
    capture     = (state_q == S_WAIT) && (wait_q == WAIT_W'(MEM_LATENCY - 1));
    weight_last = (lane_q == LANE_W'(LANES - 1)) ||
                  ((col_base + COL_W'(lane_q)) == COL_W'(WEIGHT_COLS - 1));
    row_last    = (row_q == RCNT_W'(FEATURE_ROWS - 1));
    group_last  = (group_q == GRP_W'(GROUPS - 1));
  end

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [SUM_W-1:0] sum;
      // Exact full-width dot product of the incoming feature row with this lane's weight column
      always_comb begin
        sum = '0;
        for (int k = 0; k < WEIGHT_ROWS; k++) begin
          sum = sum + SUM_W'(data_in[k*DATA_WIDTH +: DATA_WIDTH]) *
                      SUM_W'(scratch_q[gi][k*DATA_WIDTH +: DATA_WIDTH]);
        end
      end
      assign lane_ovf[gi] = ((sum >> DOT_PROD_WIDTH) != '0);
      assign lane_val[gi] = (lane_ovf[gi] && (SATURATE != 0)) ? {DOT_PROD_WIDTH{1'b1}}
                                                              : DOT_PROD_WIDTH'(sum);
    end
  endgenerate

  // Next-state logic: read sequencing, weight capture and result write-back
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    lane_d     = lane_q;
    row_d      = row_q;
    group_d    = group_q;
    wait_d     = wait_q;
    overflow_d = overflow_q;
    scratch_d  = scratch_q;
    result_d   = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ISSUE;
          phase_d    = 1'b0;
          lane_d     = '0;
          row_d      = '0;
          group_d    = '0;
          wait_d     = '0;
          overflow_d = 1'b0;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        wait_d  = '0;
      end
      S_WAIT: begin
        if (!capture) begin
          wait_d = wait_q + WAIT_W'(1);
        end else if (!phase_q) begin
          for (int l = 0; l < LANES; l++) begin
            if (lane_q == LANE_W'(l)) scratch_d[l] = data_in;
          end
          state_d = S_ISSUE;
          if (weight_last) begin
            phase_d = 1'b1;
            row_d   = '0;
          end else begin
            lane_d = lane_q + LANE_W'(1);
          end
        end else begin
          // Only lanes mapping onto a real column write; the partial last group skips the rest
          for (int r = 0; r < FEATURE_ROWS; r++) begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
              for (int l = 0; l < LANES; l++) begin
                if ((row_q == RCNT_W'(r)) && ((col_base + COL_W'(l)) == COL_W'(c))) begin
                  result_d[r][c] = lane_val[l];
                end
              end
            end
          end
          for (int l = 0; l < LANES; l++) begin
            if (((col_base + COL_W'(l)) < COL_W'(WEIGHT_COLS)) && lane_ovf[l]) overflow_d = 1'b1;
          end
          if (!row_last) begin
            row_d   = row_q + RCNT_W'(1);
            state_d = S_ISSUE;
          end else if (group_last) begin
            state_d = S_DONE;
          end else begin
            group_d = group_q + GRP_W'(1);
            phase_d = 1'b0;
            lane_d  = '0;
            state_d = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset aborts any run and clears buffers immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      lane_q     <= '0;
      row_q      <= '0;
      group_q    <= '0;
      wait_q     <= '0;
      overflow_q <= 1'b0;
      for (int l = 0; l < LANES; l++) scratch_q[l] <= '0;
      for (int r = 0; r < FEATURE_ROWS; r++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) result_q[r][c] <= '0;
      end
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      lane_q     <= lane_d;
      row_q      <= row_d;
      group_q    <= group_d;
      wait_q     <= wait_d;
      overflow_q <= overflow_d;
      scratch_q  <= scratch_d;
      result_q   <= result_d;
    end
  end

  // Memory port and status outputs decoded from the current state
  always_comb begin
    enable_read  = (state_q == S_ISSUE);
    read_address = '0;
    if (state_q == S_ISSUE) begin
      read_address = phase_q ? (FEATURE_BASE + ADDRESS_WIDTH'(row_q))
                             : (WEIGHT_BASE + ADDRESS_WIDTH'(col_base) + ADDRESS_WIDTH'(lane_q));
    end
    busy     = (state_q == S_ISSUE) || (state_q == S_WAIT);
    done     = (state_q == S_DONE);
    overflow = overflow_q;
  end

  // Combinational row read-out; rows beyond the buffer read as zero
  always_comb begin
    fm_wm_row = '0;
    for (int r = 0; r < FEATURE_ROWS; r++) begin
      if (read_row == ROW_W'(r)) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          fm_wm_row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = result_q[r][c];
        end
      end
    end
  end

endmodule

// File: tb/tb_transformation_engine_mlane.sv
// Scoreboard bench for transformation_engine_mlane. Instance A uses the default
// configuration. Instance B uses LANES=3, MEM_LATENCY=3 and SATURATE=0. Both share
// the memory image, start, reset and read_row.
module tb_transformation_engine_mlane;
  localparam int WR = 96, DW = 5, FR = 6, WC = 3, DPW = 16, AW = 13;
  localparam int WORD = WR * DW;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [2:0] read_row = '0;
  logic [WORD-1:0] din_a, din_b;
  logic [AW-1:0] addr_a, addr_b, lat_a = '0, lat_b = '0;
  logic en_a, en_b, busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [WC*DPW-1:0] row_a, row_b;

  always #5 clk = ~clk;

  transformation_engine_mlane #(.LANES(2), .MEM_LATENCY(1), .SATURATE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start), .data_in(din_a), .read_address(addr_a),
    .enable_read(en_a), .read_row(read_row), .fm_wm_row(row_a), .busy(busy_a),
    .done(done_a), .overflow(ovf_a));

  transformation_engine_mlane #(.LANES(3), .MEM_LATENCY(3), .SATURATE(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .data_in(din_b), .read_address(addr_b),
    .enable_read(en_b), .read_row(read_row), .fm_wm_row(row_b), .busy(busy_b),
    .done(done_b), .overflow(ovf_b));

  // Memory image: weight columns at 0..2, feature rows at 0x200..0x205
  logic [WORD-1:0] wcol [WC];
  logic [WORD-1:0] frow [FR];

  function automatic logic [WORD-1:0] mem_rd(input logic [AW-1:0] a);
    if (a < AW'(WC)) return wcol[int'(a)];
    if (a >= 13'h200 && a < 13'h200 + AW'(FR)) return frow[int'(a - 13'h200)];
    return '0;
  endfunction

  // Address is latched on issue and held, so data is valid by every capture edge
  always @(posedge clk) begin
    if (en_a) lat_a <= addr_a;
    if (en_b) lat_b <= addr_b;
  end
  always_comb din_a = mem_rd(lat_a);
  always_comb din_b = mem_rd(lat_b);

  int cyc = 0, base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; int cy; } rd_t;
  typedef struct { int cy; logic ovf; } dn_t;
  typedef struct { int r; logic [WC*DPW-1:0] a; logic [WC*DPW-1:0] b; } rw_t;
  rd_t qa[$], qb[$];
  dn_t da[$], db[$];
  rw_t qr[$];

  int tests = 0, fails = 0;
  bit mon_en = 1'b1, rd_req = 1'b0, seen_a = 1'b0, seen_b = 1'b0;
  logic [WC*DPW-1:0] ea [FR], eb [FR], pa [FR], pb [FR];
  logic eovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [AW-1:0] a);
    tests++;
    fails++;
    $display("FAIL %s: unexpected read at 0x%0h, nothing expected", name, a);
  endtask

  // Monitor: reads, done/overflow and row read-outs popped against the scoreboard
  logic dprev_a = 1'b0, dprev_b = 1'b0;
  always @(negedge clk) begin
    rd_t e; dn_t d; rw_t w;
    if (!reset && mon_en) begin
      if (en_a) begin
        if (qa.size() == 0) unexpected("rd_a", addr_a);
        else begin
          e = qa.pop_front();
          chk("rd_a_addr", 64'(addr_a), 64'(e.addr));
          chk("rd_a_cycle", 64'(cyc - base), 64'(e.cy));
          $display("[TB] A read 0x%0h in cycle %0d", addr_a, cyc - base);
        end
      end
      if (en_b) begin
        if (qb.size() == 0) unexpected("rd_b", addr_b);
        else begin
          e = qb.pop_front();
          chk("rd_b_addr", 64'(addr_b), 64'(e.addr));
          chk("rd_b_cycle", 64'(cyc - base), 64'(e.cy));
          $display("[TB] B read 0x%0h in cycle %0d", addr_b, cyc - base);
        end
      end
      if (done_a && !dprev_a) begin
        seen_a = 1'b1;
        if (da.size() == 0) unexpected("done_a", '0);
        else begin
          d = da.pop_front();
          chk("done_a_cycle", 64'(cyc - base), 64'(d.cy));
          chk("done_a_overflow", 64'(ovf_a), 64'(d.ovf));
          $display("[TB] A done in cycle %0d overflow=%0d", cyc - base, ovf_a);
        end
      end
      if (done_b && !dprev_b) begin
        seen_b = 1'b1;
        if (db.size() == 0) unexpected("done_b", '0);
        else begin
          d = db.pop_front();
          chk("done_b_cycle", 64'(cyc - base), 64'(d.cy));
          chk("done_b_overflow", 64'(ovf_b), 64'(d.ovf));
          $display("[TB] B done in cycle %0d overflow=%0d", cyc - base, ovf_b);
        end
      end
    end
    if (rd_req) begin
      if (qr.size() == 0) unexpected("row", '0);
      else begin
        w = qr.pop_front();
        chk($sformatf("row_a[%0d]", w.r), 64'(row_a), 64'(w.a));
        chk($sformatf("row_b[%0d]", w.r), 64'(row_b), 64'(w.b));
        $display("[TB] row %0d A=%h B=%h", w.r, row_a, row_b);
      end
    end
    dprev_a = done_a;
    dprev_b = done_b;
  end

  task automatic fill(input bit all_max);
    for (int c = 0; c < WC; c++)
      for (int k = 0; k < WR; k++) wcol[c][k*DW +: DW] = all_max ? 5'd31 : 5'($urandom_range(31, 0));
    for (int r = 0; r < FR; r++)
      for (int k = 0; k < WR; k++) frow[r][k*DW +: DW] = all_max ? 5'd31 : 5'($urandom_range(31, 0));
  endtask

  // Reference: exact dot products, then clamp (A) or wrap (B) to 16 bits
  task automatic model();
    int s;
    eovf = 1'b0;
    for (int r = 0; r < FR; r++) begin
      for (int c = 0; c < WC; c++) begin
        s = 0;
        for (int k = 0; k < WR; k++) s += int'(frow[r][k*DW +: DW]) * int'(wcol[c][k*DW +: DW]);
        if (s >= 65536) eovf = 1'b1;
        ea[r][c*DPW +: DPW] = (s >= 65536) ? 16'hFFFF : 16'(s);
        eb[r][c*DPW +: DPW] = 16'(s);
      end
    end
  endtask

  task automatic push_expect();
    int i;
    // A: group 0 = columns 0,1 then rows; group 1 = column 2 then rows; two cycles per read
    i = 0;
    for (int g = 0; g < 2; g++) begin
      for (int c = g * 2; c < WC && c < g * 2 + 2; c++) begin qa.push_back('{AW'(c), 1 + 2 * i}); i++; end
      for (int r = 0; r < FR; r++) begin qa.push_back('{13'h200 + AW'(r), 1 + 2 * i}); i++; end
    end
    // B: a single group of three columns then rows; four cycles per read
    i = 0;
    for (int c = 0; c < WC; c++) begin qb.push_back('{AW'(c), 1 + 4 * i}); i++; end
    for (int r = 0; r < FR; r++) begin qb.push_back('{13'h200 + AW'(r), 1 + 4 * i}); i++; end
    da.push_back('{31, eovf});
    db.push_back('{37, eovf});
  endtask

  task automatic check_rows();
    for (int r = 0; r < 8; r++) begin
      @(posedge clk); #1;
      read_row = 3'(r);
      rd_req = 1'b1;
      qr.push_back('{r, (r < FR) ? ea[r] : '0, (r < FR) ? eb[r] : '0});
    end
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic run(input bit hold, input bit pulses, input bit midread);
    int k;
    rw_t m;
    model();
    push_expect();
    seen_a = 1'b0;
    seen_b = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    base = cyc;
    for (k = 1; k <= 200 && !(seen_a && seen_b); k++) begin
      @(posedge clk); #1;
      if (k == 1) begin
        if (!hold) start = 1'b0;
        chk("busy_a_cycle1", 64'(busy_a), 64'd1);
        chk("overflow_a_cleared", 64'(ovf_a), 64'd0);
        chk("overflow_b_cleared", 64'(ovf_b), 64'd0);
      end
      if (pulses && (k == 5 || k == 20)) start = 1'b1;
      if (pulses && (k == 6 || k == 21)) start = 1'b0;
      if (midread && k == 10) begin
        // A has written row 0 of columns 0/1 only; B has not written row 0 yet
        m.r = 0;
        m.a = {pa[0][2*DPW +: DPW], ea[0][0 +: 2*DPW]};
        m.b = pb[0];
        read_row = '0;
        rd_req = 1'b1;
        qr.push_back(m);
      end
      if (midread && k == 11) rd_req = 1'b0;
    end
    if (!(seen_a && seen_b)) begin
      tests++;
      fails++;
      $display("FAIL run_timeout: done_a=%0d done_b=%0d after 200 cycles, need both 1", seen_a, seen_b);
    end
    if (hold) begin
      for (int j = 0; j < 5; j++) begin
        @(posedge clk); #1;
        chk("hold_done_a", 64'(done_a), 64'd1);
        chk("hold_done_b", 64'(done_b), 64'd1);
      end
      start = 1'b0;
      @(posedge clk); #1;
      chk("release_done_a", 64'(done_a), 64'd0);
      chk("release_busy_a", 64'(busy_a), 64'd0);
    end
    check_rows();
    for (int r = 0; r < FR; r++) begin pa[r] = ea[r]; pb[r] = eb[r]; end
  endtask

  initial begin
    void'($urandom(32'd1234));
    for (int r = 0; r < FR; r++) begin pa[r] = '0; pb[r] = '0; end
    fill(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_enable_read", 64'(en_a), 64'd0);
    chk("reset_address", 64'(addr_a), 64'd0);
    chk("reset_busy", 64'(busy_a), 64'd0);
    chk("reset_done", 64'(done_b), 64'd0);
    chk("reset_overflow", 64'(ovf_a), 64'd0);
    chk("reset_row_a", 64'(row_a), 64'd0);
    chk("reset_row_b", 64'(row_b), 64'd0);
    reset = 1'b0;

    // Random data with stray start pulses while busy
    run(1'b0, 1'b1, 1'b0);

    // Abort mid-run in cycle 9, an issue cycle for both instances
    fill(1'b0);
    mon_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_enable_read_a", 64'(en_a), 64'd0);
    chk("abort_enable_read_b", 64'(en_b), 64'd0);
    chk("abort_busy_a", 64'(busy_a), 64'd0);
    chk("abort_busy_b", 64'(busy_b), 64'd0);
    for (int r = 0; r < FR; r++) begin
      read_row = 3'(r);
      #1;
      chk($sformatf("abort_row_a[%0d]", r), 64'(row_a), 64'd0);
      chk($sformatf("abort_row_b[%0d]", r), 64'(row_b), 64'd0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    for (int r = 0; r < FR; r++) begin pa[r] = '0; pb[r] = '0; end

    // Fresh run after the abort
    run(1'b0, 1'b0, 1'b0);

    // All-31 data: 92256 clamps to 65535 on A, wraps to 26720 on B
    fill(1'b1);
    run(1'b0, 1'b0, 1'b0);
    chk("max_entry_a", 64'(pa[3][DPW +: DPW]), 64'd65535);
    chk("max_entry_b", 64'(pb[3][DPW +: DPW]), 64'd26720);

    // start held high throughout; overwrites results, clears overflow, mid-run row peek
    fill(1'b0);
    run(1'b1, 1'b0, 1'b1);

    chk("reads_left_a", 64'(qa.size()), 64'd0);
    chk("reads_left_b", 64'(qb.size()), 64'd0);
    chk("rows_left", 64'(qr.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
